// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the single memory port.
// The slave modport is the arbiter's view. The master modport is the requester/memory side.
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m1_req;
  logic [15:0] m0_addr;
  logic [15:0] m1_addr;
  logic [15:0] m0_wdata;
  logic [15:0] m1_wdata;
  logic [1:0]  m0_we;
  logic [1:0]  m1_we;
  logic        m1_lock;
  logic        m0_gnt;
  logic        m1_gnt;
  logic        m0_rvalid;
  logic        m1_rvalid;
  logic [15:0] m0_rdata;
  logic [15:0] m1_rdata;
  logic [15:0] mem_addr;
  logic        mem_oe;
  logic [15:0] mem_dout;
  logic [1:0]  mem_we;
  logic [15:0] mem_din;

  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we, m1_lock, mem_din,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output mem_addr, mem_oe, mem_dout, mem_we
  );

  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we, m1_lock, mem_din,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  mem_addr, mem_oe, mem_dout, mem_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: round-robin with a bounded m1 lock, one registered access per cycle.
// Define DMEM_ARB_FIXED_PRI_EN to give m0 fixed priority instead of round-robin.
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 8
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

  typedef enum logic {LOCK_OPEN, LOCK_HELD} lock_state_e;

  lock_state_e lock_q, lock_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;

`ifndef DMEM_ARB_FIXED_PRI_EN
  typedef enum logic {LAST_M0, LAST_M1} last_e;
  last_e last_q, last_d;
`endif

  logic        acc_vld_q, acc_vld_d;
  logic        acc_own_q, acc_own_d;
  logic [15:0] acc_addr_q, acc_addr_d;
  logic [15:0] acc_wdata_q, acc_wdata_d;
  logic [1:0]  acc_we_q, acc_we_d;

  logic gnt0, gnt1, m0_pri, mem_live, rd_live;

  // Grant decode; the lock outranks arbitration unless the lock budget is spent and m0 waits.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    m0_pri = 1'b1;
`ifndef DMEM_ARB_FIXED_PRI_EN
    m0_pri = (last_q == LAST_M1);
`endif
    if (rst) begin
      if (lock_q == LOCK_HELD && bus.m1_req) begin
        if (lock_cnt_q >= LOCK_LIM && bus.m0_req) gnt0 = 1'b1;
        else                                      gnt1 = 1'b1;
      end else if (bus.m0_req && bus.m1_req) begin
        gnt0 = m0_pri;
        gnt1 = !m0_pri;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  always_comb begin
    lock_d     = LOCK_OPEN;
    lock_cnt_d = '0;
    if (gnt1 && bus.m1_lock) begin
      lock_d     = LOCK_HELD;
      lock_cnt_d = (lock_cnt_q == 4'hF) ? lock_cnt_q : lock_cnt_q + 4'd1;
    end
`ifndef DMEM_ARB_FIXED_PRI_EN
    last_d = last_q;
    if (gnt0)      last_d = LAST_M0;
    else if (gnt1) last_d = LAST_M1;
`endif
    acc_vld_d   = gnt0 || gnt1;
    acc_own_d   = gnt1;
    acc_addr_d  = gnt1 ? bus.m1_addr  : bus.m0_addr;
    acc_wdata_d = gnt1 ? bus.m1_wdata : bus.m0_wdata;
    acc_we_d    = gnt1 ? bus.m1_we    : bus.m0_we;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_q      <= LOCK_OPEN;
      lock_cnt_q  <= '0;
`ifndef DMEM_ARB_FIXED_PRI_EN
      last_q      <= LAST_M1;
`endif
      acc_vld_q   <= 1'b0;
      acc_own_q   <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      acc_we_q    <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_cnt_q  <= lock_cnt_d;
`ifndef DMEM_ARB_FIXED_PRI_EN
      last_q      <= last_d;
`endif
      acc_vld_q   <= acc_vld_d;
      acc_own_q   <= acc_own_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      acc_we_q    <= acc_we_d;
    end
  end

  // Outputs are gated by rst so the memory port is quiet for the whole reset cycle.
  always_comb begin
    mem_live      = rst && acc_vld_q;
    rd_live       = mem_live && (acc_we_q == 2'b00);
    bus.m0_gnt    = gnt0;
    bus.m1_gnt    = gnt1;
    bus.mem_addr  = mem_live ? acc_addr_q  : '0;
    bus.mem_dout  = mem_live ? acc_wdata_q : '0;
    bus.mem_we    = mem_live ? acc_we_q    : '0;
    bus.mem_oe    = rd_live;
    bus.m0_rvalid = rd_live && !acc_own_q;
    bus.m1_rvalid = rd_live && acc_own_q;
    bus.m0_rdata  = (rd_live && !acc_own_q) ? bus.mem_din : '0;
    bus.m1_rdata  = (rd_live && acc_own_q)  ? bus.mem_din : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter LOCK_MAX, default 8, giving the maximum number of consecutive locked m1 grants (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-004 The block SHALL have ports m0_req/m1_req, input, 1 bit each: the requester wants a memory access this cycle.
REQ-005 The block SHALL have ports m0_addr/m1_addr, input, 16 bits each: byte address.
REQ-006 The block SHALL have ports m0_wdata/m1_wdata, input, 16 bits each: write data.
REQ-007 The block SHALL have ports m0_we/m1_we, input, 2 bits each: byte write enables [1]=low byte, [0]=high byte; 00 = read.
REQ-008 The block SHALL have port m1_lock, input, 1 bit: m1 asks to keep ownership on its next cycle.
REQ-009 The block SHALL have ports m0_gnt/m1_gnt, output, 1 bit each: request accepted this cycle (combinational).
REQ-010 The block SHALL have ports m0_rvalid/m1_rvalid, output, 1 bit each: read data valid.
REQ-011 The block SHALL have ports m0_rdata/m1_rdata, output, 16 bits each: read data.
REQ-012 The block SHALL have ports mem_addr (16 bits), mem_oe (1 bit), mem_dout (16 bits) and mem_we (2 bits), outputs, to the single data memory port.
REQ-013 The block SHALL have port mem_din, input, 16 bits: combinational memory read data.

Function
REQ-014 At most one of m0_gnt and m1_gnt SHALL be high in any cycle; gnt SHALL never be high without the matching req.
REQ-015 A lone requester SHALL be granted in the same cycle.
REQ-016 When both requesters are active, no lock is held and FIXED_PRI is not in effect, the requester not granted last SHALL win (round-robin); the last-grant pointer updates on every grant.
REQ-017 A granted access SHALL be registered and SHALL appear on mem_* exactly one cycle after the grant: mem_addr=addr, mem_dout=wdata, mem_we=we, mem_oe=(we==00).
REQ-018 In cycles with no registered access, mem_oe SHALL be 0, mem_we SHALL be 00, and mem_addr/mem_dout SHALL be 0.
REQ-019 For a read, the owner's rvalid SHALL be high in the mem cycle (grant+1) and its rdata SHALL equal mem_din in that cycle; rvalid SHALL be 0 for writes.
REQ-020 rdata of the non-owner SHALL be 0.
REQ-021 Throughput SHALL be one grant per cycle with no bubbles between back-to-back grants.
REQ-022 Lock: if m1 is granted with m1_lock=1, m1 SHALL hold ownership for the next cycle and m0_gnt SHALL be 0 while the lock is held; a 4-bit lock counter SHALL increment on each locked m1 grant.
REQ-023 When the lock counter reaches LOCK_MAX and m0_req=1, m1 SHALL be denied for exactly one cycle, m0 SHALL be granted, and the counter SHALL clear.
REQ-024 The lock SHALL release, and the counter SHALL clear, on any cycle m1_req=0 or m1_lock=0.
REQ-025 A locked m1 with m1_req=0 SHALL NOT block m0.
REQ-026 Requests SHALL NOT be queued: an ungranted requester holds req and its inputs until granted.

Reset
REQ-027 While rst=0, all gnt, rvalid, rdata and mem_* outputs SHALL be 0 and the lock counter and lock SHALL be cleared.
REQ-028 The reset value of the last-grant pointer SHALL be m1, so m0 wins the first contention.
REQ-029 An access granted in the cycle rst is sampled low SHALL be discarded and SHALL never reach mem_*.

Configuration
REQ-030 When DMEM_ARB_FIXED_PRI_EN is defined, m0 SHALL win every contention not blocked by an m1 lock, and the pointer SHALL be unused.
REQ-031 When DMEM_ARB_FIXED_PRI_EN is undefined, round-robin per REQ-016 SHALL apply.
REQ-032 Lock behaviour SHALL be identical in both configurations.

Verification
REQ-033 Reset release with m0_req=m1_req=1, both reads, addr 0x0010/0x0020 -> m0_gnt cycle 1, m1_gnt cycle 2; mem_addr 0x0010 then 0x0020; each rvalid one cycle after its grant.
REQ-034 m0 write addr 0x0004, wdata 0xABCD, we=11 -> next cycle mem_we=11, mem_dout=0xABCD, mem_oe=0, m0_rvalid=0.
REQ-035 m1_lock=1 held, m0_req=1 continuously, LOCK_MAX=8 -> 8 consecutive m1 grants, then one m0 grant, then m1 regains.
REQ-036 Lock drop: m1_lock goes 1->0 mid-burst with m0 waiting -> m0 granted the following cycle; lock counter reads 0.
REQ-037 rst driven 0 in the same cycle as an m1 grant -> mem_* stay 0 and no m1_rvalid next cycle.
REQ-038 With DMEM_ARB_FIXED_PRI_EN defined and both requesting, no lock, for 5 cycles -> m0_gnt=1 in all 5 cycles and m1_gnt=0.
